// File: rtl/codec_init_sequencer.sv
// Power-up / on-request WM8731 configuration: walks seven 24-bit I2C write frames through I2cSender.
// Latency: first o_i2c_start one cycle after i_start is sampled; strobes spaced finish-delay + GAP_CYCLES + 1.
// Backpressure: each frame stalls until i_i2c_finished (aborts after TIMEOUT_CYCLES); i_start ignored while busy.
module codec_init_sequencer #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_i2c_start,
    output logic [23:0] o_i2c_dat,
    input  logic        i_i2c_finished,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [2:0]  o_index
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [2:0] LAST_INDEX = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;
    logic [GW-1:0] gcnt;
    logic [GW-1:0] gcnt_n;
    logic [2:0]    index_n;
    logic          busy_n;
    logic          done_n;
    logic          error_n;
    logic          start_n;
    logic [23:0]   dat_n;
    logic          advance;

    // Codec register table: device address 0x34, then {7-bit register, 9-bit data}.
    function automatic logic [23:0] frame(input logic [2:0] idx);
        case (idx)
            3'd0:    frame = 24'h341E00;  // codec reset
            3'd1:    frame = 24'h340815;  // analog path
            3'd2:    frame = 24'h340A00;  // digital path
            3'd3:    frame = 24'h340C00;  // power-down control
            3'd4:    frame = 24'h340E42;  // interface format, master / I2S
            3'd5:    frame = 24'h341019;  // sampling control
            default: frame = 24'h341201;  // active
        endcase
    endfunction

    // Next-state and next-output logic; outputs are registered from the values computed here
    // so that the strobe and its frame appear together in the SEND cycle.
    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        gcnt_n  = gcnt;
        index_n = o_index;
        busy_n  = o_busy;
        done_n  = o_done;
        error_n = o_error;
        start_n = 1'b0;
        dat_n   = o_i2c_dat;
        advance = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_n = S_SEND;
                    index_n = 3'd0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                end
            end
            S_SEND: begin
                state_n = S_WAIT;
                tcnt_n  = '0;
            end
            S_WAIT: begin
                // Finished takes priority over a coincident timeout.
                if (i_i2c_finished) begin
                    if (GAP_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_n = S_GAP;
                        gcnt_n  = '0;
                    end
                end else if (int'(tcnt) + 1 >= TIMEOUT_CYCLES - 1) begin
                    state_n = S_ERROR;
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            S_GAP: begin
                if (int'(gcnt) + 1 >= GAP_CYCLES) begin
                    advance = 1'b1;
                end else begin
                    gcnt_n = gcnt + GW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Move on to the next frame, or finish after the last one.
        if (advance) begin
            if (o_index == LAST_INDEX) begin
                state_n = S_DONE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end else begin
                state_n = S_SEND;
                index_n = o_index + 3'd1;
            end
        end

        if (state_n == S_SEND) begin
            start_n = 1'b1;
            dat_n   = frame(index_n);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            gcnt        <= '0;
            o_index     <= 3'd0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_i2c_start <= 1'b0;
            o_i2c_dat   <= 24'h000000;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            gcnt        <= gcnt_n;
            o_index     <= index_n;
            o_busy      <= busy_n;
            o_done      <= done_n;
            o_error     <= error_n;
            o_i2c_start <= start_n;
            o_i2c_dat   <= dat_n;
        end
    end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: one instance with a 4-cycle gap, one with no gap.
// Expected strobes (cycle, frame) are queued when a start is issued; a monitor pops and compares.
// A responder plays I2cSender, answering each strobe after a programmable delay.
module tb_codec_init_sequencer;

    typedef struct {
        int          at;
        logic [23:0] dat;
    } exp_t;

    logic [23:0] tbl [7] = '{24'h341E00, 24'h340815, 24'h340A00, 24'h340C00,
                             24'h340E42, 24'h341019, 24'h341201};

    localparam int TMO = 50;

    logic clk;
    logic rst_n;
    logic start;
    logic sel;
    logic spur_fin;
    logic resp_fin;

    logic        start0, fin0, st0, busy0, done0, err0;
    logic [23:0] dat0;
    logic [2:0]  idx0;
    logic        start1, fin1, st1, busy1, done1, err1;
    logic [23:0] dat1;
    logic [2:0]  idx1;

    logic        obs_st, obs_busy, obs_done, obs_err, other_st;
    logic [23:0] obs_dat;
    logic [2:0]  obs_idx;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    int resp_f = 30;
    int silent_idx = -1;
    bit spur_send = 0;
    bit spur_gap = 0;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign fin0   = (resp_fin | spur_fin) & ~sel;
    assign fin1   = (resp_fin | spur_fin) & sel;

    assign obs_st   = sel ? st1 : st0;
    assign obs_dat  = sel ? dat1 : dat0;
    assign obs_busy = sel ? busy1 : busy0;
    assign obs_done = sel ? done1 : done0;
    assign obs_err  = sel ? err1 : err0;
    assign obs_idx  = sel ? idx1 : idx0;
    assign other_st = sel ? st0 : st1;

    codec_init_sequencer #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(TMO)) u_gap4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0),
        .o_i2c_start(st0), .o_i2c_dat(dat0), .i_i2c_finished(fin0),
        .o_busy(busy0), .o_done(done0), .o_error(err0), .o_index(idx0)
    );

    codec_init_sequencer #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) u_gap0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
        .o_i2c_start(st1), .o_i2c_dat(dat1), .i_i2c_finished(fin1),
        .o_busy(busy1), .o_done(done1), .o_error(err1), .o_index(idx1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // I2cSender stand-in: finished pulses F cycles after each strobe, except for the silent frame.
    int pend = -1;
    int pend2 = -1;
    initial resp_fin = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend     = -1;
            pend2    = -1;
            resp_fin = 1'b0;
        end else begin
            resp_fin = 1'b0;
            if (pend2 > 0) begin
                pend2--;
                if (pend2 == 0) resp_fin = 1'b1;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    resp_fin = 1'b1;
                    if (spur_gap) pend2 = 2;
                end
            end
            if (obs_st) begin
                if (!(silent_idx >= 0 && obs_dat == tbl[silent_idx])) pend = resp_f;
                if (spur_send) resp_fin = 1'b1;
            end
        end
    end

    // Scoreboard monitor: every strobe must match the head of the expected queue.
    bit          prev_st = 0;
    bit          have_last = 0;
    int          last_s = 0;
    logic [23:0] last_dat = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_st = 0;
        end else begin
            if (other_st) chk("idle_instance_strobe", 32'(other_st), 0);
            if (obs_st) begin
                exp_t e;
                chk("strobe_back_to_back", 32'(prev_st), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(obs_st), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_frame", 32'(obs_dat), 32'(e.dat));
                    chk("strobe_cycle", cyc, e.at);
                end
                last_s    = cyc;
                last_dat  = obs_dat;
                have_last = 1;
            end else if (obs_busy && have_last && cyc <= last_s + resp_f) begin
                chk("dat_stable_in_wait", 32'(obs_dat), 32'(last_dat));
            end
            prev_st = obs_st;
        end
    end

    // Issue a start pulse and queue the strobes the reference timeline predicts.
    task automatic issue_start(input int nfr, output int c);
        int p;
        p = resp_f + (sel ? 0 : 4) + 1;
        @(negedge clk);
        c = cyc;
        for (int k = 0; k < nfr; k++) exp_q.push_back('{at: c + 1 + k * p, dat: tbl[k]});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_flag(input bit want_done, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (want_done ? obs_done : obs_err) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_strobe"}, 32'(st0), 0);
        chk({tag, "_dat"},    32'(dat0), 0);
        chk({tag, "_busy"},   32'(busy0), 0);
        chk({tag, "_done"},   32'(done0), 0);
        chk({tag, "_error"},  32'(err0), 0);
        chk({tag, "_index"},  32'(idx0), 0);
    endtask

    task automatic full_run(input string tag);
        int c;
        int at;
        int p;
        p = resp_f + (sel ? 0 : 4) + 1;
        issue_start(7, c);
        wait_flag(1'b1, 2000, at);
        chk({tag, "_done_cycle"}, at, c + 1 + 7 * p);
        chk({tag, "_busy_end"},  32'(obs_busy), 0);
        chk({tag, "_error_end"}, 32'(obs_err), 0);
        chk({tag, "_index_end"}, 32'(obs_idx), 6);
        repeat (5) @(negedge clk);
        chk({tag, "_leftover"}, exp_q.size(), 0);
    endtask

    initial begin
        int c;
        int at;
        int p;
        rst_n    = 1'b0;
        start    = 1'b0;
        sel      = 1'b0;
        spur_fin = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        chk("reset_g0_busy", 32'(busy1), 0);
        rst_n = 1'b1;

        // Spurious finished while idle: nothing may happen.
        repeat (2) @(negedge clk);
        spur_fin = 1'b1;
        repeat (3) @(negedge clk);
        spur_fin = 1'b0;
        @(negedge clk);
        chk("idle_spur_busy", 32'(busy0), 0);
        chk("idle_spur_index", 32'(idx0), 0);

        full_run("normal");

        // Spurious finished in SEND and GAP, plus a start pulse during a WAIT.
        spur_send = 1;
        spur_gap  = 1;
        p = resp_f + 5;
        issue_start(7, c);
        while (cyc < c + 1 + p + 10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_flag(1'b1, 2000, at);
        chk("spur_done_cycle", at, c + 1 + 7 * p);
        chk("spur_index_end", 32'(obs_idx), 6);
        spur_send = 0;
        spur_gap  = 0;
        repeat (5) @(negedge clk);
        chk("spur_leftover", exp_q.size(), 0);

        // Frame 2 never answered: abort after the timeout.
        silent_idx = 2;
        issue_start(3, c);
        wait_flag(1'b0, 2000, at);
        chk("timeout_cycle", at, c + 1 + 2 * p + TMO);
        chk("timeout_busy", 32'(obs_busy), 0);
        chk("timeout_done", 32'(obs_done), 0);
        chk("timeout_index", 32'(obs_idx), 2);
        repeat (30) @(negedge clk);
        chk("timeout_error_hold", 32'(obs_err), 1);
        chk("timeout_leftover", exp_q.size(), 0);
        silent_idx = -1;

        // Restart from the error state.
        issue_start(7, c);
        chk("restart_error_clear", 32'(obs_err), 0);
        chk("restart_busy", 32'(obs_busy), 1);
        chk("restart_index", 32'(obs_idx), 0);
        wait_flag(1'b1, 2000, at);
        chk("restart_done_cycle", at, c + 1 + 7 * p);
        repeat (5) @(negedge clk);
        chk("restart_leftover", exp_q.size(), 0);

        // Asynchronous reset during the frame 4 WAIT.
        issue_start(7, c);
        while (cyc < c + 1 + 4 * p + 5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_busy", 32'(busy0), 0);
        full_run("after_reset");

        // No gap, finished one cycle after each strobe: strobes every two cycles.
        sel    = 1'b1;
        resp_f = 1;
        @(negedge clk);
        full_run("gap0");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
